// File: rtl/fp_pkg.sv
// -----------------------------------------------------------------------------
// fp_pkg
// Shared definitions for the single-precision divide path: field widths,
// exponent bias, canonical quiet NaN, packed result/flag types and the
// round/pack FSM state encoding.
// -----------------------------------------------------------------------------
package fp_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int Q_W    = FRAC_W + 3;   // hidden bit + fraction + guard + round
    localparam int BIAS   = 127;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    typedef struct packed {
        logic invalid;
        logic divzero;
        logic overflow;
        logic underflow;
        logic inexact;
    } fp_flags_t;

    // ST_SUBR is the extra re-round cycle of the subnormal path; it is
    // never entered when subnormal support is compiled out.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_NORM,
        ST_ROUND,
        ST_PACK,
        ST_SUBR,
        ST_HOLD
    } state_t;

endpackage

// File: rtl/fp_rne_round.sv
// -----------------------------------------------------------------------------
// fp_rne_round
// Combinational round-to-nearest-even increment of a mantissa given its
// guard, round and sticky bits.
//   m_in   : mantissa before rounding (LSB is the tie-break bit)
//   g/r/s  : guard, round, sticky
//   m_out  : rounded mantissa (wraps to zero when carry is set)
//   carry  : carry out of the mantissa MSB
// -----------------------------------------------------------------------------
module fp_rne_round #(
    parameter int W = 24
) (
    input  logic [W-1:0] m_in,
    input  logic         g,
    input  logic         r,
    input  logic         s,
    output logic [W-1:0] m_out,
    output logic         carry
);

    logic inc;

    // Round up above half, or exactly half with an odd LSB.
    assign inc = g & (r | s | m_in[0]);
    assign {carry, m_out} = {1'b0, m_in} + {{W{1'b0}}, inc};

endmodule

// File: rtl/fp_div_round_pack.sv
// -----------------------------------------------------------------------------
// fp_div_round_pack
// Final stage of the FP divider: exponent computation, RNE rounding,
// IEEE-754 special cases and packing into a single-precision word.
//
// Optional build macro FP_DIV_SUBNORMAL_EN: produce gradual-underflow
// (subnormal) results instead of flushing them to zero; such results take
// one extra cycle.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      operand bundle handshake
//   quotient, remainder      divider mantissa quotient and final remainder
//   normalize                1: quotient already normalised, 0: pre-shifted
//   sign_*, exp_*, is_*      operand signs, biased exponents, class flags
//   out_valid / out_ready    result handshake
//   result                   packed IEEE result
//   flag_*                   exception flags, valid with out_valid
// -----------------------------------------------------------------------------
module fp_div_round_pack #(
    parameter int EXP_W  = fp_pkg::EXP_W,
    parameter int FRAC_W = fp_pkg::FRAC_W,
    parameter int Q_W    = fp_pkg::Q_W,
    parameter int BIAS   = fp_pkg::BIAS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [Q_W-1:0]          quotient,
    input  logic [Q_W-1:0]          remainder,
    input  logic                    normalize,
    input  logic                    sign_a,
    input  logic                    sign_b,
    input  logic [EXP_W-1:0]        exp_a,
    input  logic [EXP_W-1:0]        exp_b,
    input  logic                    is_zero_a,
    input  logic                    is_zero_b,
    input  logic                    is_inf_a,
    input  logic                    is_inf_b,
    input  logic                    is_nan_a,
    input  logic                    is_nan_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+FRAC_W:0]   result,
    output logic                    flag_invalid,
    output logic                    flag_divzero,
    output logic                    flag_overflow,
    output logic                    flag_underflow,
    output logic                    flag_inexact
);
    import fp_pkg::*;

    localparam int E_W = EXP_W + 2;   // signed working exponent
    localparam int M_W = Q_W - 2;     // hidden bit + fraction
    localparam int R_W = 1 + EXP_W + FRAC_W;

    localparam logic signed [E_W-1:0] ZERO_E = '0;
    localparam logic signed [E_W-1:0] ONE_E  = E_W'(1);
    localparam logic signed [E_W-1:0] BIAS_E = E_W'(BIAS);
    localparam logic signed [E_W-1:0] E_MAX  = E_W'((1 << EXP_W) - 1);
    localparam logic [M_W-1:0]        M_ONE  = {1'b1, {(M_W-1){1'b0}}};
    localparam logic [R_W-1:0]        QNAN_R = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

    state_t                  state;
    fp_flags_t               flags_r;

    // Captured operand bundle
    logic [Q_W-1:0]          q_r;
    logic [Q_W-1:0]          rem_r;
    logic                    norm_r, sa_r, sb_r;
    logic [EXP_W-1:0]        ea_r, eb_r;
    logic                    za_r, zb_r, ia_r, ib_r, na_r, nb_r;

    // Working values
    logic signed [E_W-1:0]   e_r;
    logic                    g_r, r_r, s_r, inexact_r;
    logic [M_W-1:0]          m_r;

    logic                    sign_q, any_nan;
    logic [R_W-1:0]          inf_v, zero_v;
    logic [M_W-1:0]          rnd_in, rnd_out;
    logic                    rnd_carry;

    assign sign_q  = sa_r ^ sb_r;
    assign any_nan = na_r | nb_r | (za_r & zb_r) | (ia_r & ib_r);
    assign inf_v   = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    assign zero_v  = {sign_q, {(R_W-1){1'b0}}};

    assign flag_invalid   = flags_r.invalid;
    assign flag_divzero   = flags_r.divzero;
    assign flag_overflow  = flags_r.overflow;
    assign flag_underflow = flags_r.underflow;
    assign flag_inexact   = flags_r.inexact;

    // One rounder serves both the normal round cycle and the subnormal
    // re-round cycle; g_r/r_r/s_r are rewritten before the latter.
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    always_comb begin
        rnd_in = q_r[Q_W-1:2];
        if (state == ST_SUBR) rnd_in = m_r;
    end

    fp_rne_round #(.W(M_W)) u_rne (
        .m_in  (rnd_in),
        .g     (g_r),
        .r     (r_r),
        .s     (s_r),
        .m_out (rnd_out),
        .carry (rnd_carry)
    );

`ifdef FP_DIV_SUBNORMAL_EN
    // Below this exponent every significant bit shifts past the round bit.
    localparam logic signed [E_W-1:0] E_TINY = E_W'(-(FRAC_W + 1));

    logic [E_W-1:0] sh;
    logic [Q_W-1:0] sh_q;
    logic           sh_lost;

    // Denormalise {1,frac,G,R} by 1-e; bits falling off join the sticky.
    always_comb begin
        sh      = ONE_E - e_r;
        sh_q    = q_r >> sh;
        sh_lost = |(q_r & ~({Q_W{1'b1}} << sh));
    end
`endif

    // NOTE: state is assigned with <= only, so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            flags_r   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        // NOTE: datapath registers are not reset; they are always written before being consumed.
                        q_r      <= quotient;
                        rem_r    <= remainder;
                        norm_r   <= normalize;
                        sa_r     <= sign_a;
                        sb_r     <= sign_b;
                        ea_r     <= exp_a;
                        eb_r     <= exp_b;
                        za_r     <= is_zero_a;
                        zb_r     <= is_zero_b;
                        ia_r     <= is_inf_a;
                        ib_r     <= is_inf_b;
                        na_r     <= is_nan_a;
                        nb_r     <= is_nan_b;
                        in_ready <= 1'b0;
                        state    <= ST_NORM;
                    end
                end

                ST_NORM: begin
                    // A pre-shifted quotient means the true exponent is one lower.
                    e_r   <= $signed({2'b00, ea_r}) - $signed({2'b00, eb_r}) + BIAS_E
                             - (norm_r ? ZERO_E : ONE_E);
                    g_r   <= q_r[1];
                    r_r   <= q_r[0];
                    s_r   <= |rem_r;
                    state <= ST_ROUND;
                end

                ST_ROUND: begin
                    m_r       <= rnd_carry ? M_ONE : rnd_out;
                    e_r       <= e_r + (rnd_carry ? ONE_E : ZERO_E);
                    inexact_r <= g_r | r_r | s_r;
                    state     <= ST_PACK;
                end

                ST_PACK: begin
                    out_valid <= 1'b1;
                    state     <= ST_HOLD;
                    flags_r   <= '0;
                    if (any_nan) begin
                        result          <= QNAN_R;
                        flags_r.invalid <= 1'b1;
                    end else if (zb_r && !za_r && !ia_r) begin
                        result          <= inf_v;
                        flags_r.divzero <= 1'b1;
                    end else if (ia_r) begin
                        result <= inf_v;
                    end else if (za_r || ib_r) begin
                        result <= zero_v;
                    end else if (e_r >= E_MAX) begin
                        result           <= inf_v;
                        flags_r.overflow <= 1'b1;
                        flags_r.inexact  <= 1'b1;
                    end else if (e_r <= ZERO_E) begin
`ifdef FP_DIV_SUBNORMAL_EN
                        if (e_r < E_TINY) begin
                            result            <= zero_v;
                            flags_r.underflow <= 1'b1;
                            flags_r.inexact   <= 1'b1;
                        end else begin
                            m_r       <= sh_q[Q_W-1:2];
                            g_r       <= sh_q[1];
                            r_r       <= sh_q[0];
                            s_r       <= s_r | sh_lost;
                            out_valid <= 1'b0;
                            state     <= ST_SUBR;
                        end
`else
                        result            <= zero_v;
                        flags_r.underflow <= 1'b1;
                        flags_r.inexact   <= 1'b1;
`endif
                    end else begin
                        result          <= {sign_q, e_r[EXP_W-1:0], m_r[FRAC_W-1:0]};
                        flags_r.inexact <= inexact_r;
                    end
                end

                ST_SUBR: begin
                    // The shifted mantissa MSB is 0, so rounding cannot carry out;
                    // a round-up into bit M_W-1 lands in exponent field 1.
                    result            <= {sign_q, {(EXP_W-1){1'b0}}, rnd_out};
                    flags_r.underflow <= g_r | r_r | s_r;
                    flags_r.inexact   <= g_r | r_r | s_r;
                    out_valid         <= 1'b1;
                    state             <= ST_HOLD;
                end

                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div_round_pack.sv
// -----------------------------------------------------------------------------
// tb_fp_div_round_pack
// Directed bench for fp_div_round_pack with hand-computed expected results.
// -----------------------------------------------------------------------------
module tb_fp_div_round_pack;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [25:0] quotient = '0;
    logic [25:0] remainder = '0;
    logic        normalize = 1'b0;
    logic        sign_a = 1'b0, sign_b = 1'b0;
    logic [7:0]  exp_a = '0, exp_b = '0;
    logic        is_zero_a = 1'b0, is_zero_b = 1'b0;
    logic        is_inf_a = 1'b0, is_inf_b = 1'b0;
    logic        is_nan_a = 1'b0, is_nan_b = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        flag_invalid, flag_divzero, flag_overflow, flag_underflow, flag_inexact;
    logic [4:0]  flags_v;

    int checks = 0;
    int errors = 0;

    assign flags_v = {flag_invalid, flag_divzero, flag_overflow, flag_underflow, flag_inexact};

    always #5 clk = ~clk;

    fp_div_round_pack dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .quotient       (quotient),
        .remainder      (remainder),
        .normalize      (normalize),
        .sign_a         (sign_a),
        .sign_b         (sign_b),
        .exp_a          (exp_a),
        .exp_b          (exp_b),
        .is_zero_a      (is_zero_a),
        .is_zero_b      (is_zero_b),
        .is_inf_a       (is_inf_a),
        .is_inf_b       (is_inf_b),
        .is_nan_a       (is_nan_a),
        .is_nan_b       (is_nan_b),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .result         (result),
        .flag_invalid   (flag_invalid),
        .flag_divzero   (flag_divzero),
        .flag_overflow  (flag_overflow),
        .flag_underflow (flag_underflow),
        .flag_inexact   (flag_inexact)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // cls = {zero_a, zero_b, inf_a, inf_b, nan_a, nan_b}
    task automatic set_ops(input logic [7:0] ea, input logic [7:0] eb, input logic norm,
                           input logic [25:0] q, input logic [25:0] rem,
                           input logic sa, input logic sb, input logic [5:0] cls);
        exp_a     = ea;
        exp_b     = eb;
        normalize = norm;
        quotient  = q;
        remainder = rem;
        sign_a    = sa;
        sign_b    = sb;
        {is_zero_a, is_zero_b, is_inf_a, is_inf_b, is_nan_a, is_nan_b} = cls;
    endtask

    // Accept one bundle, wait (bounded) for the result, check it, then hand it off.
    task automatic xact(input string tag, input logic [31:0] exp_res, input logic [4:0] exp_fl);
        int cyc;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "_latency"}, 32'(cyc), 32'd3);
        check({tag, "_result"}, result, exp_res);
        check({tag, "_flags"}, 32'(flags_v), 32'(exp_fl));
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check({tag, "_done_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_done_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int seen;

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'h0);
        check("rst_flags", 32'(flags_v), 32'd0);
        rst = 1'b0;

        // 6.0 / 2.0 = 3.0
        set_ops(8'd129, 8'd128, 1'b1, 26'h300_0000, 26'h0, 1'b0, 1'b0, 6'b000000);
        xact("div_6_2", 32'h4040_0000, 5'b00000);

        // -6.0 / 2.0 = -3.0
        set_ops(8'd129, 8'd128, 1'b1, 26'h300_0000, 26'h0, 1'b1, 1'b0, 6'b000000);
        xact("div_neg6_2", 32'hC040_0000, 5'b00000);

        // 1.0 / 3.0, pre-shifted quotient, sticky remainder
        set_ops(8'd127, 8'd128, 1'b0, 26'h2AA_AAAA, 26'h1, 1'b0, 1'b0, 6'b000000);
        xact("div_1_3", 32'h3EAA_AAAB, 5'b00001);

        // Rounding carry out of the mantissa bumps the exponent
        set_ops(8'd127, 8'd127, 1'b1, 26'h3FF_FFFF, 26'h0, 1'b0, 1'b0, 6'b000000);
        xact("round_carry", 32'h4000_0000, 5'b00001);

        // Exact tie, even LSB: stays
        set_ops(8'd127, 8'd127, 1'b1, 26'h200_0002, 26'h0, 1'b0, 1'b0, 6'b000000);
        xact("tie_even", 32'h3F80_0000, 5'b00001);

        // Exact tie, odd LSB: rounds up to even
        set_ops(8'd127, 8'd127, 1'b1, 26'h200_0006, 26'h0, 1'b0, 1'b0, 6'b000000);
        xact("tie_odd", 32'h3F80_0002, 5'b00001);

        // 1.0 / 0 -> +inf, divide-by-zero
        set_ops(8'd127, 8'd0, 1'b1, 26'h200_0000, 26'h0, 1'b0, 1'b0, 6'b010000);
        xact("div_by_zero", 32'h7F80_0000, 5'b01000);

        // 0 / 0 -> qNaN, invalid
        set_ops(8'd0, 8'd0, 1'b1, 26'h0, 26'h0, 1'b0, 1'b0, 6'b110000);
        xact("zero_zero", 32'h7FC0_0000, 5'b10000);

        // -inf / finite -> -inf, no flags
        set_ops(8'd255, 8'd127, 1'b1, 26'h200_0000, 26'h0, 1'b1, 1'b0, 6'b001000);
        xact("inf_fin", 32'hFF80_0000, 5'b00000);

        // finite / -inf -> -0, no flags
        set_ops(8'd127, 8'd255, 1'b1, 26'h200_0000, 26'h0, 1'b0, 1'b1, 6'b000100);
        xact("fin_inf", 32'h8000_0000, 5'b00000);

        // Overflow: e = 254 - 126 + 127 = 255
        set_ops(8'd254, 8'd126, 1'b1, 26'h200_0000, 26'h0, 1'b0, 1'b0, 6'b000000);
        xact("overflow", 32'h7F80_0000, 5'b00101);

        // Deep underflow: e = 1 - 200 + 127 = -72 -> signed zero
        set_ops(8'd1, 8'd200, 1'b1, 26'h200_0000, 26'h0, 1'b1, 1'b0, 6'b000000);
        xact("underflow", 32'h8000_0000, 5'b00011);

        // Backpressure: hold the result while a second bundle is offered
        set_ops(8'd129, 8'd128, 1'b1, 26'h300_0000, 26'h0, 1'b0, 1'b0, 6'b000000);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        seen = 0;
        while (!out_valid && seen < 20) begin
            @(posedge clk);
            #1;
            seen++;
        end
        check("bp_latency", 32'(seen), 32'd3);
        set_ops(8'd127, 8'd128, 1'b0, 26'h2AA_AAAA, 26'h1, 1'b0, 1'b0, 6'b000000);
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold_result", result, 32'h4040_0000);
            check("bp_hold_flags", 32'(flags_v), 32'd0);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("bp_single_handshake", 32'(seen), 32'd0);

        // Reset while in ROUND discards the bundle
        set_ops(8'd127, 8'd128, 1'b0, 26'h2AA_AAAA, 26'h1, 1'b0, 1'b0, 6'b000000);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_result", result, 32'h0);
        check("midrst_flags", 32'(flags_v), 32'd0);
        seen = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("midrst_no_stale", 32'(seen), 32'd0);

        // Operation resumes normally after the reset
        set_ops(8'd129, 8'd128, 1'b1, 26'h300_0000, 26'h0, 1'b0, 1'b0, 6'b000000);
        xact("after_reset", 32'h4040_0000, 5'b00000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_div_round_pack.md
Name: fp_div_round_pack

Overview:
- Downstream stage of the mantissa divider in the FP divide path.
- Consumes the divider's quotient, remainder and normalize flag, together with the operand signs, exponents and class flags captured by the unpack stage.
- Computes the result exponent, rounds round-to-nearest-even, applies IEEE-754 special cases, and emits a packed single-precision result with exception flags over a valid/ready handshake.

Parameters:
- EXP_W, 8, exponent field width.
- FRAC_W, 23, stored fraction width.
- Q_W, 26, divider quotient width: hidden bit + FRAC_W + guard + round.
- BIAS, 127, exponent bias.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operand bundle valid (driven from divider valid_out).
- in_ready  out  1  block can accept a bundle.
- quotient  in  Q_W  divider quotient; MSB is the leading 1 for finite nonzero operands.
- remainder  in  Q_W  divider final remainder; nonzero means sticky.
- normalize  in  1  1: dividend mantissa >= divisor mantissa; 0: pre-shifted.
- sign_a, sign_b  in  1 each  operand signs.
- exp_a, exp_b  in  EXP_W each  biased operand exponents.
- is_zero_a, is_zero_b, is_inf_a, is_inf_b, is_nan_a, is_nan_b  in  1 each  operand class flags.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  1+EXP_W+FRAC_W  packed IEEE result.
- flag_invalid, flag_divzero, flag_overflow, flag_underflow, flag_inexact  out  1 each  exception flags, valid with out_valid.

Behaviour:
- Reset (rst high at a clk edge):
  - state IDLE; in_ready=1, out_valid=0, result=0, all flags 0.
  - Reset mid-operation discards the bundle in flight; no partial output appears.
- FSM IDLE -> NORM -> ROUND -> PACK -> HOLD -> IDLE.
- IDLE:
  - in_ready=1; on in_valid&&in_ready, register all inputs and go to NORM.
  - in_ready=0 in every other state.
- NORM:
  - e = exp_a - exp_b + BIAS - (normalize ? 0 : 1), computed signed on EXP_W+2 bits.
  - G = quotient[1], R = quotient[0], S = |remainder.
- ROUND:
  - inc = G & (R | S | quotient[2]).
  - m = quotient[Q_W-1:2] + inc.
  - On carry-out, set m = 1.000…, e = e+1.
  - inexact = G|R|S.
- PACK, with special precedence as follows:
  1. Any NaN, 0/0, or inf/inf -> 0x7FC00000 (canonical qNaN), flag_invalid=1.
  2. Finite nonzero / 0 -> signed inf, flag_divzero=1.
  3. inf / finite -> signed inf, no flags.
  4. 0/finite or finite/inf -> signed zero, no flags.
  5. e >= 2^EXP_W - 1 -> signed inf, flag_overflow=1, flag_inexact=1.
  6. e <= 0 -> handled per the Optional Feature section.
  7. Otherwise -> {sign_a^sign_b, e[EXP_W-1:0], m[FRAC_W-1:0]}, flag_inexact=inexact.
- Result sign is sign_a^sign_b for all non-NaN cases.
- PACK sets out_valid=1 and moves to HOLD.
- Latency: out_valid rises on the 3rd clk edge after the accept edge.
- HOLD:
  - result and flags stay stable while out_valid && !out_ready.
  - On out_ready, out_valid drops on that edge and state returns to IDLE.
  - Throughput is one result per 5 cycles minimum.
- in_valid asserted outside IDLE is ignored; the upstream holds it.

Optional Feature:
- Macro FP_DIV_SUBNORMAL_EN.
- Defined: for e <= 0, right-shift {1,frac,G,R} by 1-e, OR the shifted-out bits into S, re-round RNE, and emit exponent field 0.
  - This may round up into the minimum normal (field 1).
  - If e < -FRAC_W-1, emit signed zero.
  - flag_underflow = inexact after shift.
  - The re-round uses one extra internal cycle in PACK; latency becomes 4.
- Undefined: e <= 0 flushes to signed zero with flag_underflow=1 and flag_inexact=1; latency stays 3.

Decomposition:
- Shared package fp_pkg holds:
  - EXP_W, FRAC_W, BIAS, QNAN constant.
  - typedef fp32_t as a packed struct {sign, exp, frac}.
  - typedef fp_flags_t as a packed struct of the five flags.
  - the state enum.
- One sub-module, fp_rne_round: combinational RNE increment plus carry, shared by the normal path and the subnormal path.

Test Plan:
- 6.0/2.0: exp_a=129, exp_b=128, normalize=1, quotient=26'h3000000, remainder=0 -> result 0x40400000, no flags, out_valid 3 cycles after accept.
- 1.0/3.0: exp_a=127, exp_b=128, normalize=0, quotient=26'h2AAAAAA, remainder nonzero -> result 0x3EAAAAAB, flag_inexact=1.
- 1.0/0: is_zero_b=1 -> result 0x7F800000, flag_divzero=1; 0/0 -> result 0x7FC00000, flag_invalid=1.
- Overflow: exp_a=254, exp_b=126, normalize=1, quotient=26'h2000000 -> result 0x7F800000, flag_overflow=1, flag_inexact=1.
- Backpressure: hold out_ready=0 for 10 cycles -> result/flags stable, in_ready=0, second in_valid ignored; release -> one handshake, back to IDLE.
- Reset mid-operation: assert rst in the ROUND state -> next cycle out_valid=0, in_ready=1, result=0, no stale output afterwards.
